// File: rtl/pipelined_addsub_seg.sv
// Pipelined add/subtract unit: WIDTH bits split into SEG-bit carry segments, one segment per stage,
// with valid/ready handshaking and a global stall driven by the output register.
module pipelined_addsub_seg #(
  parameter int WIDTH = 32,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int STAGES = WIDTH / SEG;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  always_comb begin
    adv   = !out_valid || out_ready;
    b_eff = in_sub ? ~in_b : in_b;
    c0    = in_sub ? ~in_cin : in_cin;
  end

  assign in_ready = adv;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    // Operands entering stage k only carry the bits not yet added (k*SEG and up);
    // the result register carries every bit already produced (below (k+1)*SEG).
    localparam int OPW = WIDTH - k * SEG;
    localparam int SW  = (k + 1) * SEG;

    logic [OPW-1:0] a_in;
    logic [OPW-1:0] b_in;
    logic           c_in;
    logic           v_in;
    logic [SEG:0]   seg_sum;
    logic [SW-1:0]  s_d;
    logic [SW-1:0]  s_q;
    logic           c_d;
    logic           c_q;
    logic           v_d;
    logic           v_q;

    if (k == 0) begin : g_src
      assign a_in = in_a;
      assign b_in = b_eff;
      assign c_in = c0;
      assign v_in = in_valid;
      always_comb s_d = seg_sum[SEG-1:0];
    end else begin : g_src
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      always_comb s_d = {seg_sum[SEG-1:0], g_stage[k-1].s_q};
    end

    always_comb begin
      seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};
      c_d     = seg_sum[SEG];
      v_d     = v_in;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        s_q <= s_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [OPW-SEG-1:0] a_d;
      logic [OPW-SEG-1:0] a_q;
      logic [OPW-SEG-1:0] b_d;
      logic [OPW-SEG-1:0] b_q;

      always_comb begin
        a_d = a_in[OPW-1:SEG];
        b_d = b_in[OPW-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_tail
      // The final stage sees the operand MSBs directly, so flags are registered alongside the sum.
      logic ovf_d;
      logic ovf_q;
      logic zero_d;
      logic zero_q;

      always_comb begin
        ovf_d  = (a_in[SEG-1] == b_in[SEG-1]) && (seg_sum[SEG-1] != a_in[SEG-1]);
        zero_d = (s_d == '0);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign out_sum   = g_stage[STAGES-1].s_q;
  assign out_cout  = g_stage[STAGES-1].c_q;
  assign out_ovf   = g_stage[STAGES-1].g_tail.ovf_q;
  assign out_zero  = g_stage[STAGES-1].g_tail.zero_q;
endmodule
